// File: rtl/xor_descrambler.sv
// Additive LFSR descrambler (x^16+x^14+x^13+x^11+1) with sync-word keystream realignment.
// Optional lock-loss detection after FRAME_LEN words without sync: define XOR_DESCR_RESYNC_EN.
module xor_descrambler #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
   parameter int               FRAME_LEN = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_sync,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_sync,
   output logic             locked,
   output logic             lost
);

   // state | meaning
   // HUNT  | not aligned: non-sync words accepted and dropped, waiting for a sync word
   // RUN   | aligned: every accepted word is descrambled and emitted
   typedef enum logic [0:0] {HUNT, RUN} state_t;

   localparam logic [6:0] FRAME_TC = 7'(FRAME_LEN);

   state_t           state, state_nx;
   logic [WIDTH-1:0] lfsr, lfsr_nx;
   logic [6:0]       cnt, cnt_nx;
   logic             m_valid_nx, m_sync_nx, lost_nx;
   logic [WIDTH-1:0] m_data_nx;
   logic [WIDTH-1:0] key;
   logic             take, emit;

   function automatic logic [15:0] adv16(input logic [15:0] s);
      logic [15:0] r;
      logic        fb;
      r = s;
      for (int i = 0; i < 16; i++) begin
         fb = r[15] ^ r[13] ^ r[12] ^ r[10];
         r  = {r[14:0], fb};
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= HUNT;
         lfsr    <= SEED;
         cnt     <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_sync  <= 1'b0;
         lost    <= 1'b0;
      end else begin
         state   <= state_nx;
         lfsr    <= lfsr_nx;
         cnt     <= cnt_nx;
         m_valid <= m_valid_nx;
         m_data  <= m_data_nx;
         m_sync  <= m_sync_nx;
         lost    <= lost_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      lfsr_nx    = lfsr;
      cnt_nx     = cnt;
      m_valid_nx = m_valid;
      m_data_nx  = m_data;
      m_sync_nx  = m_sync;
      lost_nx    = 1'b0;
      emit       = 1'b0;

      // HUNT never stalls the link: unaligned traffic is simply discarded
      s_ready = (state == HUNT) ? 1'b1 : (!m_valid || m_ready);
      take    = s_valid && s_ready;
      key     = s_sync ? SEED : lfsr;

      if (m_ready) m_valid_nx = 1'b0;

      case (state)
         HUNT: begin
            if (take && s_sync) begin
               emit     = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (take) begin
               if (s_sync) begin
                  emit = 1'b1;
`ifdef XOR_DESCR_RESYNC_EN
               end else if (cnt == FRAME_TC) begin
                  state_nx = HUNT;
                  lost_nx  = 1'b1;
                  lfsr_nx  = SEED;
                  cnt_nx   = '0;
`endif
               end else begin
                  emit = 1'b1;
               end
            end
         end
         default: state_nx = HUNT;
      endcase

      if (emit) begin
         m_valid_nx = 1'b1;
         m_data_nx  = s_data ^ key;
         m_sync_nx  = s_sync;
         lfsr_nx    = adv16(key);
         // Saturates at FRAME_TC; with lock-loss enabled that value is never exceeded anyway
         if (s_sync)               cnt_nx = 7'd1;
         else if (cnt != FRAME_TC) cnt_nx = cnt + 7'd1;
      end
   end

   assign locked = (state == RUN);

endmodule

// File: tb/tb_xor_descrambler.sv
// Directed bench for xor_descrambler: hunt, seed, round trip, backpressure, resync, reset, lock loss.
module tb_xor_descrambler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid, s_ready, s_sync;
   logic [15:0] s_data;
   logic        m_valid, m_ready, m_sync;
   logic [15:0] m_data;
   logic        locked, lost;

   int          n_checks = 0;
   int          n_errors = 0;
   int          stalls   = 0;
   logic [15:0] ms;
   logic [15:0] got_q[$];
   logic [15:0] exp_q[$];

   xor_descrambler dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_sync  (s_sync),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_sync  (m_sync),
      .locked  (locked),
      .lost    (lost)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (rst_n && m_valid && m_ready) got_q.push_back(m_data);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] step16(input logic [15:0] s);
      logic [15:0] r;
      r = s;
      for (int i = 0; i < 16; i++) r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
      return r;
   endfunction

   // transmit-side additive scrambler
   task automatic model(input logic [15:0] orig, input logic sy, output logic [15:0] scr);
      logic [15:0] k;
      k   = sy ? 16'hACE1 : ms;
      scr = orig ^ k;
      ms  = step16(k);
   endtask

   task automatic xfer(input logic [15:0] d, input logic sy);
      int n;
      n = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_sync  = sy;
      #1;
      while (!s_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      stalls += n;
      if (!s_ready) check("xfer_timeout", 32'(s_ready), 32'd1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_sync  = 1'b0;
   endtask

   task automatic stream(input int n, input int sa, input int sb);
      logic [15:0] o, sc;
      logic        sy;
      for (int i = 0; i < n; i++) begin
         o  = 16'($random);
         sy = (i == sa) || (i == sb);
         model(o, sy, sc);
         exp_q.push_back(o);
         xfer(sc, sy);
      end
   endtask

   task automatic compare(input string tag);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) check({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
         else n_checks++;
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] o, sc;
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_sync = 1'b0; m_ready = 1'b1; ms = 16'hACE1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data",  32'(m_data),  32'd0);
      check("rst_locked",  32'(locked),  32'd0);
      check("rst_lost",    32'(lost),    32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 3; i++) begin
         xfer(16'h1234 + 16'(i), 1'b0);
         check("hunt_m_valid", 32'(m_valid), 32'd0);
         check("hunt_s_ready", 32'(s_ready), 32'd1);
         check("hunt_locked",  32'(locked),  32'd0);
      end
      check("hunt_no_output", 32'(got_q.size()), 32'd0);

      xfer(16'h0000, 1'b1);
      check("seed_m_valid", 32'(m_valid), 32'd1);
      check("seed_m_data",  32'(m_data),  32'h0000ACE1);
      check("seed_m_sync",  32'(m_sync),  32'd1);
      check("seed_locked",  32'(locked),  32'd1);
      xfer(16'hACE1, 1'b1);
      check("seed2_m_data", 32'(m_data),  32'h0);
      check("seed2_m_sync", 32'(m_sync),  32'd1);
      @(posedge clk); #1;
      got_q.delete();

      stalls = 0;
      stream(40, 0, -1);
      check("rt_stalls", 32'(stalls), 32'd0);
      compare("rt");

      stream(8, 0, -1);
      m_ready = 1'b0;
      o = 16'($random);
      model(o, 1'b0, sc);
      exp_q.push_back(o);
      s_valid = 1'b1; s_data = sc; s_sync = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_s_ready", 32'(s_ready), 32'd0);
         check("bp_m_data",  32'(m_data),  32'(exp_q[7]));
      end
      m_ready = 1'b1;
      xfer(sc, 1'b0);
      stream(8, -1, -1);
      compare("bp");

      stream(9, 0, -1);
      model(16'hACE1, 1'b1, sc);
      exp_q.push_back(16'hACE1);
      xfer(16'h0000, 1'b1);
      check("resync_m_data", 32'(m_data), 32'h0000ACE1);
      check("resync_m_sync", 32'(m_sync), 32'd1);
      stream(5, -1, -1);
      compare("resync");

      stream(4, 0, -1);
      check("pre_rst_m_valid", 32'(m_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_m_valid", 32'(m_valid), 32'd0);
      check("midrst_locked",  32'(locked),  32'd0);
      check("midrst_m_data",  32'(m_data),  32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      got_q.delete();
      exp_q.delete();
      xfer(16'h5555, 1'b0);
      check("post_rst_hunt", 32'(m_valid), 32'd0);

`ifdef XOR_DESCR_RESYNC_EN
      stream(64, 0, -1);
      xfer(16'h9999, 1'b0);
      check("loss_lost",    32'(lost),    32'd1);
      check("loss_locked",  32'(locked),  32'd0);
      check("loss_m_valid", 32'(m_valid), 32'd0);
      @(posedge clk); #1;
      check("loss_pulse_end", 32'(lost), 32'd0);
      compare("loss");
      xfer(16'h0000, 1'b1);
      check("relock_m_data", 32'(m_data), 32'h0000ACE1);
      check("relock_locked", 32'(locked), 32'd1);
`else
      stream(70, 0, -1);
      check("nolos_locked", 32'(locked), 32'd1);
      check("nolos_lost",   32'(lost),   32'd0);
      compare("nolos");
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
